pwr_supervisor: RTL and testbench
=================================

# pwr_supervisor

Power-path supervisor that sequences the power stage around the voltage/current fault detector. It ramps the stage on through a soft-start window and holds the detector in reset whenever power is off. It reacts to the detector's warning, fault and shutdown indications by derating, tripping, cooling down and retrying. After a bounded number of failed retries it latches a lockout that only an explicit operator clear releases.

## Interface
- SOFTSTART_CYC, 16: cycles spent in SOFTSTART before RUN (≥2).
- COOLDOWN_CYC, 64: cycles spent in COOLDOWN after a trip (≥2).
- WARN_LIMIT, 8: consecutive warning cycles to enter DERATE, and consecutive clear cycles to leave it (≥1).
- MAX_RETRY, 3: trips tolerated before LOCKOUT (1..7).
- RUN_CLEAR_CYC, 256: consecutive trip-free cycles in RUN/DERATE that clear retry_cnt.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en_req  in  1  operator power-on request, level.
- clr_lockout  in  1  single-cycle pulse; releases LOCKOUT.
- det_warning  in  1  detector warning flag.
- det_fault  in  1  detector fault flag.
- det_shutdown  in  1  detector shutdown flag.
- pwr_en  out  1  power stage enable.
- derate  out  1  request reduced operating point.
- det_rstn  out  1  active-low reset to detector.
- lockout  out  1  lockout latched.
- trip_evt  out  1  one-cycle pulse per trip.
- retry_cnt  out  3  trips since last clear, saturating at MAX_RETRY.
- state  out  3  current state encoding.

## Operation
The state encoding is OFF=0, SOFTSTART=1, RUN=2, DERATE=3, TRIP=4, COOLDOWN=5, LOCKOUT=6.

Per-state outputs:
- OFF: pwr_en=0, det_rstn=0. en_req=1 moves to SOFTSTART.
- SOFTSTART: pwr_en=1, det_rstn=1. det_warning is ignored.
  - det_fault or det_shutdown moves to TRIP.
  - Otherwise en_req=0 moves to OFF.
  - Otherwise, timer expiry moves to RUN.
- RUN: pwr_en=1, det_rstn=1.
  - det_fault or det_shutdown moves to TRIP.
  - Otherwise en_req=0 moves to OFF.
  - Otherwise, det_warning high for WARN_LIMIT consecutive cycles moves to DERATE.
- DERATE: as RUN plus derate=1. det_warning low for WARN_LIMIT consecutive cycles moves to RUN.
- TRIP: lasts exactly 1 cycle. pwr_en=0, det_rstn=0, trip_evt=1, retry_cnt increments (saturating).
  - If the post-increment value is ≥ MAX_RETRY, go to LOCKOUT.
  - Otherwise go to COOLDOWN.
- COOLDOWN: pwr_en=0, det_rstn=0. Lasts exactly COOLDOWN_CYC cycles; en_req and detector flags are ignored. At expiry, en_req=1 goes to SOFTSTART, otherwise OFF.
- LOCKOUT: pwr_en=0, det_rstn=0, lockout=1. clr_lockout moves to OFF and clears retry_cnt. en_req is ignored.

Counters and priority:
- The warning counter resets on every state change and on each polarity change of det_warning.
- The clear counter runs only in RUN/DERATE and resets on leaving them. On reaching RUN_CLEAR_CYC it zeroes retry_cnt and holds.
- Priority within a cycle: rst > fault/shutdown > en_req drop > clr_lockout > timer expiry > warning counting.
- Undefined state encodings (7) go to TRIP.

## Timing
- Reset values: state=OFF, pwr_en=0, derate=0, det_rstn=0, lockout=0, trip_evt=0, retry_cnt=0, all counters 0.
- All outputs are registered and update on the same edge as the state register. Latency from input sample to output change is 1 clock.
- SOFTSTART occupies exactly SOFTSTART_CYC cycles when there is no abort. The timer loads on the entry edge and expiry is detected at count 1.
- The fault response is 1 cycle: pwr_en falls on the edge that samples det_fault high.
- DERATE entry occurs on the edge sampling the WARN_LIMIT-th consecutive warning.
- Asserting rst mid-sequence forces pwr_en=0 immediately, without waiting for a clock edge.
- Inputs are synchronous to clk; no synchronizers are included.

## Structure
- Package pwr_pkg holds:
  - the state encoding constants;
  - default parameter values;
  - the counter width derived from the maximum of SOFTSTART_CYC and COOLDOWN_CYC.
- Sub-module sup_timer: a loadable down-counter with load, value and expired ports. It is shared by SOFTSTART and COOLDOWN.
- The warning and clear counters stay inline.

## Test plan
Test parameters: SOFTSTART_CYC=4, COOLDOWN_CYC=8, WARN_LIMIT=3, MAX_RETRY=2, RUN_CLEAR_CYC=16.

- Nominal power-up: raise en_req from OFF.
  - pwr_en and det_rstn go to 1 on the next edge.
  - state=RUN after 4 cycles.
  - Drop en_req and pwr_en=0 on the next edge.
- Derate: in RUN, det_warning high for 3 cycles gives DERATE and derate=1. Low for 2 cycles, high again: stays in DERATE. Low for 3 cycles returns to RUN.
- Trip and retry: pulse det_fault in RUN.
  - trip_evt lasts 1 cycle, retry_cnt=1, then 8 cycles of COOLDOWN with det_rstn=0.
  - With en_req held, the sequence then goes to SOFTSTART and on to RUN.
- Lockout: two faults give retry_cnt=2 and LOCKOUT with lockout=1, and en_req is ignored. A clr_lockout pulse gives OFF with retry_cnt=0.
- Retry clear: after one trip, remain in RUN for 16 cycles; retry_cnt returns to 0.
- Async reset: assert rst in SOFTSTART between clock edges. pwr_en=0 and state=OFF apply immediately, and all outputs hold their reset values.

Source files
------------

// File: rtl/pwr_pkg.sv
// Shared definitions for the power-path supervisor: state encoding,
// default parameter values and counter width helpers.
package pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_SOFTSTART = 3'd1,
    ST_RUN       = 3'd2,
    ST_DERATE    = 3'd3,
    ST_TRIP      = 3'd4,
    ST_COOLDOWN  = 3'd5,
    ST_LOCKOUT   = 3'd6
  } state_t;

  localparam int SOFTSTART_CYC_DEF = 16;
  localparam int COOLDOWN_CYC_DEF  = 64;
  localparam int WARN_LIMIT_DEF    = 8;
  localparam int MAX_RETRY_DEF     = 3;
  localparam int RUN_CLEAR_CYC_DEF = 256;

  // Bits needed to hold values 0..maxval (never less than 1).
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMR_W_DEF = cnt_width(max2(SOFTSTART_CYC_DEF, COOLDOWN_CYC_DEF));

endpackage

// File: rtl/pwr_supervisor_timer.sv
// Loadable down-counter shared by the SOFTSTART and COOLDOWN windows.
// expired flags the final cycle of a window (count == 1).
module sup_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Load on window entry, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= value;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign expired = (cnt == W'(1));

endmodule

// File: rtl/pwr_supervisor.sv
// Power-path supervisor: soft-start sequencing, warning derate, fault trip
// with cooldown/retry, and latched lockout after repeated trips.
module pwr_supervisor
  import pwr_pkg::*;
#(
  parameter int SOFTSTART_CYC = SOFTSTART_CYC_DEF,
  parameter int COOLDOWN_CYC  = COOLDOWN_CYC_DEF,
  parameter int WARN_LIMIT    = WARN_LIMIT_DEF,
  parameter int MAX_RETRY     = MAX_RETRY_DEF,
  parameter int RUN_CLEAR_CYC = RUN_CLEAR_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_req,
  input  logic       clr_lockout,
  input  logic       det_warning,
  input  logic       det_fault,
  input  logic       det_shutdown,
  output logic       pwr_en,
  output logic       derate,
  output logic       det_rstn,
  output logic       lockout,
  output logic       trip_evt,
  output logic [2:0] retry_cnt,
  output logic [2:0] state
);

  localparam int TW = cnt_width(max2(SOFTSTART_CYC, COOLDOWN_CYC));
  localparam int WW = cnt_width(WARN_LIMIT);
  localparam int CW = cnt_width(RUN_CLEAR_CYC);

  localparam logic [TW-1:0] SS_LOAD    = TW'(SOFTSTART_CYC);
  localparam logic [TW-1:0] CD_LOAD    = TW'(COOLDOWN_CYC);
  localparam logic [WW-1:0] WARN_LAST  = WW'(WARN_LIMIT - 1);
  localparam logic [CW-1:0] CLR_TOP    = CW'(RUN_CLEAR_CYC);
  localparam logic [CW-1:0] CLR_LAST   = CW'(RUN_CLEAR_CYC - 1);
  localparam logic [2:0]    RETRY_MAX  = 3'(MAX_RETRY);

  state_t          state_q, state_d;
  logic            tmr_load, tmr_expired;
  logic [TW-1:0]   tmr_value;
  logic [WW-1:0]   warn_cnt;
  logic [CW-1:0]   clr_cnt;
  logic [2:0]      retry_q;
  logic            fault, run_stay;

  assign fault    = det_fault | det_shutdown;
  assign run_stay = (state_q inside {ST_RUN, ST_DERATE}) &&
                    (state_d inside {ST_RUN, ST_DERATE});

  sup_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  // Next-state selection with fault > en_req drop > clr_lockout > timer > warning priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:       if (en_req) state_d = ST_SOFTSTART;
      ST_SOFTSTART: begin
        if (fault)            state_d = ST_TRIP;
        else if (!en_req)     state_d = ST_OFF;
        else if (tmr_expired) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fault)                                   state_d = ST_TRIP;
        else if (!en_req)                            state_d = ST_OFF;
        else if (det_warning && warn_cnt == WARN_LAST) state_d = ST_DERATE;
      end
      ST_DERATE: begin
        if (fault)                                    state_d = ST_TRIP;
        else if (!en_req)                             state_d = ST_OFF;
        else if (!det_warning && warn_cnt == WARN_LAST) state_d = ST_RUN;
      end
      ST_TRIP:      state_d = (retry_q >= RETRY_MAX) ? ST_LOCKOUT : ST_COOLDOWN;
      ST_COOLDOWN:  if (tmr_expired) state_d = en_req ? ST_SOFTSTART : ST_OFF;
      ST_LOCKOUT:   if (clr_lockout) state_d = ST_OFF;
      default:      state_d = ST_TRIP;
    endcase
  end

  // Timer loads on the edge entering either timed window.
  always_comb begin
    tmr_load  = (state_d != state_q) &&
                (state_d == ST_SOFTSTART || state_d == ST_COOLDOWN);
    tmr_value = (state_d == ST_SOFTSTART) ? SS_LOAD : CD_LOAD;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_OFF;
    else     state_q <= state_d;
  end

  // Consecutive warning (RUN) / clear (DERATE) streak; restarts on any state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   warn_cnt <= '0;
    else if (state_d != state_q)               warn_cnt <= '0;
    else if ((state_q == ST_RUN && det_warning) ||
             (state_q == ST_DERATE && !det_warning))
                                               warn_cnt <= warn_cnt + WW'(1);
    else                                       warn_cnt <= '0;
  end

  // Trip-free residency in RUN/DERATE; saturates once the retry clear has fired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    clr_cnt <= '0;
    else if (!run_stay)         clr_cnt <= '0;
    else if (clr_cnt != CLR_TOP) clr_cnt <= clr_cnt + CW'(1);
  end

  // Retry count: bump on trip, clear on lockout release or sustained clean run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         retry_q <= '0;
    else if (state_d == ST_TRIP) begin
      if (retry_q < RETRY_MAX)                       retry_q <= retry_q + 3'd1;
    end
    else if (state_q == ST_LOCKOUT && state_d == ST_OFF) retry_q <= '0;
    else if (run_stay && clr_cnt == CLR_LAST)        retry_q <= '0;
  end

  // Registered output decode of the incoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr_en   <= 1'b0;
      det_rstn <= 1'b0;
      derate   <= 1'b0;
      lockout  <= 1'b0;
      trip_evt <= 1'b0;
    end else begin
      pwr_en   <= state_d inside {ST_SOFTSTART, ST_RUN, ST_DERATE};
      det_rstn <= state_d inside {ST_SOFTSTART, ST_RUN, ST_DERATE};
      derate   <= (state_d == ST_DERATE);
      lockout  <= (state_d == ST_LOCKOUT);
      trip_evt <= (state_d == ST_TRIP);
    end
  end

  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pwr_supervisor.sv
// Self-checking bench for pwr_supervisor: directed scenarios followed by
// randomized stimulus, all checked against a cycle-level behavioural model.
module tb_pwr_supervisor;

  localparam int SS  = 4;
  localparam int CD  = 8;
  localparam int WL  = 3;
  localparam int MR  = 2;
  localparam int RCC = 16;

  logic       clk = 1'b0;
  logic       rst, en_req, clr_lockout, det_warning, det_fault, det_shutdown;
  logic       pwr_en, derate, det_rstn, lockout, trip_evt;
  logic [2:0] retry_cnt, state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: state number, cycles spent in the current state, current
  // warning/clear streak, clean run residency and retry tally.
  int m_state, m_elapsed, m_streak, m_run, m_retry;

  always #5 clk = ~clk;

  pwr_supervisor #(
    .SOFTSTART_CYC (SS),
    .COOLDOWN_CYC  (CD),
    .WARN_LIMIT    (WL),
    .MAX_RETRY     (MR),
    .RUN_CLEAR_CYC (RCC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_req       (en_req),
    .clr_lockout  (clr_lockout),
    .det_warning  (det_warning),
    .det_fault    (det_fault),
    .det_shutdown (det_shutdown),
    .pwr_en       (pwr_en),
    .derate       (derate),
    .det_rstn     (det_rstn),
    .lockout      (lockout),
    .trip_evt     (trip_evt),
    .retry_cnt    (retry_cnt),
    .state        (state)
  );

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_elapsed = 0; m_streak = 0; m_run = 0; m_retry = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int   ns;
    logic flt;
    flt = det_fault | det_shutdown;
    ns  = m_state;
    case (m_state)
      0: if (en_req) ns = 1;
      1: if (flt) ns = 4; else if (!en_req) ns = 0; else if (m_elapsed + 1 >= SS) ns = 2;
      2: if (flt) ns = 4; else if (!en_req) ns = 0;
         else if (det_warning && m_streak + 1 >= WL) ns = 3;
      3: if (flt) ns = 4; else if (!en_req) ns = 0;
         else if (!det_warning && m_streak + 1 >= WL) ns = 2;
      4: ns = (m_retry >= MR) ? 6 : 5;
      5: if (m_elapsed + 1 >= CD) ns = en_req ? 1 : 0;
      6: if (clr_lockout) ns = 0;
      default: ns = 4;
    endcase

    if (ns == 4) m_retry = (m_retry < MR) ? m_retry + 1 : MR;
    else if (m_state == 6 && ns == 0) m_retry = 0;

    if ((m_state == 2 || m_state == 3) && (ns == 2 || ns == 3)) begin
      if (m_run < RCC) begin
        m_run++;
        if (m_run == RCC) m_retry = 0;
      end
    end else m_run = 0;

    if (ns != m_state) m_streak = 0;
    else if ((m_state == 2 && det_warning) || (m_state == 3 && !det_warning)) m_streak++;
    else m_streak = 0;

    m_elapsed = (ns != m_state) ? 0 : m_elapsed + 1;
    m_state   = ns;
  endtask

  task automatic check_outputs();
    logic on;
    on = (m_state >= 1 && m_state <= 3);
    chk("state",     state,                3'(m_state));
    chk("pwr_en",    {2'b00, pwr_en},      {2'b00, on});
    chk("det_rstn",  {2'b00, det_rstn},    {2'b00, on});
    chk("derate",    {2'b00, derate},      {2'b00, m_state == 3});
    chk("lockout",   {2'b00, lockout},     {2'b00, m_state == 6});
    chk("trip_evt",  {2'b00, trip_evt},    {2'b00, m_state == 4});
    chk("retry_cnt", retry_cnt,            3'(m_retry));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; en_req = 1'b0; clr_lockout = 1'b0;
    det_warning = 1'b0; det_fault = 1'b0; det_shutdown = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_outputs();
    chk("reset_state", state, 3'd0);
    rst = 1'b0;

    // Nominal power-up and power-down.
    en_req = 1'b1;
    step();
    chk("pu_pwr_en", {2'b00, pwr_en}, 3'd1);
    chk("pu_state",  state,           3'd1);
    for (int i = 0; i < SS; i++) step();
    chk("pu_run", state, 3'd2);
    en_req = 1'b0;
    step();
    chk("pd_pwr_en", {2'b00, pwr_en}, 3'd0);

    // Derate entry, interrupted clear streak, derate exit.
    en_req = 1'b1;
    for (int i = 0; i < SS + 1; i++) step();
    det_warning = 1'b1;
    for (int i = 0; i < WL; i++) step();
    chk("drt_state", state, 3'd3);
    chk("drt_flag",  {2'b00, derate}, 3'd1);
    det_warning = 1'b0; step(); step();
    det_warning = 1'b1; step();
    chk("drt_hold", state, 3'd3);
    det_warning = 1'b0;
    for (int i = 0; i < WL; i++) step();
    chk("drt_exit", state, 3'd2);

    // Trip, cooldown and retry back into RUN.
    det_fault = 1'b1; step(); det_fault = 1'b0;
    chk("trip_evt1", {2'b00, trip_evt}, 3'd1);
    chk("trip_cnt1", retry_cnt, 3'd1);
    for (int i = 0; i < CD; i++) step();
    chk("cd_last", state, 3'd5);
    chk("cd_rstn", {2'b00, det_rstn}, 3'd0);
    step();
    chk("cd_retry", state, 3'd1);
    for (int i = 0; i < SS; i++) step();
    chk("retry_run", state, 3'd2);

    // Second trip reaches lockout; en_req ignored; clear releases it.
    det_shutdown = 1'b1; step(); det_shutdown = 1'b0;
    chk("trip_cnt2", retry_cnt, 3'd2);
    step();
    chk("lock_state", state, 3'd6);
    for (int i = 0; i < 4; i++) step();
    chk("lock_hold", {2'b00, lockout}, 3'd1);
    clr_lockout = 1'b1; step(); clr_lockout = 1'b0;
    chk("clr_state", state, 3'd0);
    chk("clr_cnt",   retry_cnt, 3'd0);

    // Retry count clears after a sustained clean run.
    for (int i = 0; i < SS + 1; i++) step();
    det_fault = 1'b1; step(); det_fault = 1'b0;
    for (int i = 0; i < CD + 1 + SS; i++) step();
    chk("rc_run", state, 3'd2);
    for (int i = 0; i < RCC - 1; i++) step();
    chk("rc_before", retry_cnt, 3'd1);
    step();
    chk("rc_after", retry_cnt, 3'd0);

    // Asynchronous reset in the middle of SOFTSTART.
    en_req = 1'b0; step();
    en_req = 1'b1; step(); step();
    #3 rst = 1'b1;
    #1;
    chk("arst_pwr_en", {2'b00, pwr_en}, 3'd0);
    chk("arst_state",  state, 3'd0);
    model_reset();
    @(posedge clk); #1;
    check_outputs();
    rst = 1'b0; en_req = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      en_req       = ($urandom_range(0, 99) < 92);
      det_fault    = ($urandom_range(0, 99) < 3);
      det_shutdown = ($urandom_range(0, 99) < 2);
      clr_lockout  = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 25) det_warning = ~det_warning;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
